// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart_tx arbiter: state encoding, default sizes
// and a one-hot to index helper used by the FSM.
package uart_arb_pkg;

    localparam int N_REQ_DEF = 3;
    localparam int LEN_W_DEF = 8;
    localparam int MAX_REQ   = 8;
    localparam int IDX_W     = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_SEND = ST_SEND,
        S_DONE = ST_DONE
    } arb_state_e;

    function automatic logic [IDX_W-1:0] oh2idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit strictly after
// last_grant, wrapping around, so the previous winner has lowest priority.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        // k runs 1..N_REQ so last_grant itself is scanned last
        for (int k = 1; k <= N_REQ; k++) begin
            if (!valid && req[(int'(last_grant) + k) % N_REQ]) begin
                winner[(int'(last_grant) + k) % N_REQ] = 1'b1;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ message sources;
// a grant covers a whole message so bytes from different sources never mix.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    input  logic [N_REQ*8-1:0]     req_data,
    output logic [N_REQ-1:0]       grant,
    output logic [LEN_W-1:0]       byte_idx,
    output logic [N_REQ-1:0]       done,
    output logic [7:0]             tx_data,
    output logic                   tx_data_valid,
    input  logic                   tx_data_ready
);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [LEN_W-1:0] byte_idx_q, byte_idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;

    logic [N_REQ-1:0] pick_oh;
    logic             pick_valid;
    logic [LEN_W-1:0] pick_len;
    logic             last_byte;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .winner     (pick_oh),
        .valid      (pick_valid)
    );

    always_comb begin
        pick_len = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_len = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // len_q is only ever read in SEND, after it has been loaded in IDLE
    assign last_byte = (byte_idx_q == len_q - LEN_W'(1));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        byte_idx_d   = byte_idx_q;
        len_d        = len_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_d    = pick_oh;
                    len_d      = pick_len;
                    byte_idx_d = '0;
                    state_d    = (pick_len == '0) ? S_DONE : S_SEND;
                end
            end
            S_SEND: begin
                if (tx_data_ready) begin
                    if (last_byte) begin
                        state_d = S_DONE;
                    end else begin
                        byte_idx_d = byte_idx_q + LEN_W'(1);
                    end
                end
            end
            S_DONE: begin
                last_grant_d = oh2idx(MAX_REQ'(grant_q));
                grant_d      = '0;
                byte_idx_d   = '0;
                state_d      = S_IDLE;
            end
            default: begin
                grant_d    = '0;
                byte_idx_d = '0;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            byte_idx_q   <= '0;
            last_grant_q <= IDX_W'(N_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            byte_idx_q   <= byte_idx_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        len_q <= len_d;
    end

    // Outputs decode straight from reset flops so a reset drops them at once
    assign grant         = grant_q;
    assign byte_idx      = byte_idx_q;
    assign tx_data_valid = (state_q == S_SEND);
    assign done          = (state_q == S_DONE) ? grant_q : '0;

    always_comb begin
        tx_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                tx_data = tx_data | req_data[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single message, round robin, backpressure,
// zero length, request drop and mid-message reset.
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int LW = 8;

    logic            sys_clk = 1'b0;
    logic            sys_rst_n;
    logic [N-1:0]    req;
    logic [N*LW-1:0] req_len;
    logic [N*8-1:0]  req_data;
    logic [N-1:0]    grant;
    logic [LW-1:0]   byte_idx;
    logic [N-1:0]    done;
    logic [7:0]      tx_data;
    logic            tx_data_valid;
    logic            tx_data_ready;

    int vec_cnt = 0;
    int err_cnt = 0;
    int hs;
    int rdy_seq [5] = '{0, 0, 1, 0, 1};
    int idx_seq [5] = '{0, 0, 0, 1, 1};
    logic [N-1:0] exp_g;

    uart_tx_arbiter #(
        .N_REQ (N),
        .LEN_W (LW)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .req           (req),
        .req_len       (req_len),
        .req_data      (req_data),
        .grant         (grant),
        .byte_idx      (byte_idx),
        .done          (done),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready)
    );

    initial forever #5 sys_clk = ~sys_clk;

    // Source s returns 'A'+16*s+k for byte k ("ABC..." for source 0)
    function automatic logic [7:0] src_byte(input int s, input logic [LW-1:0] k);
        return 8'h41 + 8'(16 * s) + k;
    endfunction

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_data[i*8 +: 8] = src_byte(i, byte_idx);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic set_len(input int s, input logic [LW-1:0] l);
        req_len[s*LW +: LW] = l;
    endtask

    task automatic do_reset();
        sys_rst_n     = 1'b0;
        req           = '0;
        req_len       = '0;
        tx_data_ready = 1'b0;
        repeat (2) @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b1;
    endtask

    task automatic chk_send(input string t, input logic [N-1:0] g, input int s, input int k);
        chk({t, "_grant"}, grant, g);
        chk({t, "_valid"}, tx_data_valid, 1);
        chk({t, "_idx"}, byte_idx, k);
        chk({t, "_data"}, tx_data, src_byte(s, LW'(k)));
        chk({t, "_nodone"}, done, 0);
    endtask

    task automatic chk_idle(input string t);
        chk({t, "_grant"}, grant, 0);
        chk({t, "_valid"}, tx_data_valid, 0);
        chk({t, "_done"}, done, 0);
        chk({t, "_txd"}, tx_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        chk_idle("rst");
        chk("rst_idx", byte_idx, 0);

        // Single request, "ABC"
        set_len(0, 3);
        tx_data_ready = 1'b1;
        req = 3'b001;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk_send("t1", 3'b001, 0, k);
            tick();
        end
        chk("t1_done", done, 3'b001);
        chk("t1_grant_in_done", grant, 3'b001);
        chk("t1_valid_in_done", tx_data_valid, 0);
        req = '0;
        tick();
        chk_idle("t1_end");
        tick();
        chk_idle("t1_stay");

        // Round robin, all three requesting with len 2
        do_reset();
        set_len(0, 2); set_len(1, 2); set_len(2, 2);
        tx_data_ready = 1'b1;
        req = 3'b111;
        tick();
        for (int m = 0; m < 4; m++) begin
            exp_g = N'(1 << (m % 3));
            chk_send("t2_b0", exp_g, m % 3, 0);
            tick();
            chk_send("t2_b1", exp_g, m % 3, 1);
            tick();
            chk("t2_done", done, exp_g);
            chk("t2_grant_done", grant, exp_g);
            if (m == 3) req = '0;
            tick();
            chk_idle("t2_gap");
            tick();
        end
        chk_idle("t2_after");

        // Backpressure
        do_reset();
        set_len(0, 2);
        req = 3'b001;
        tick();
        hs = 0;
        for (int c = 0; c < 5; c++) begin
            tx_data_ready = rdy_seq[c][0];
            chk_send("t3", 3'b001, 0, idx_seq[c]);
            if (tx_data_valid && tx_data_ready) hs++;
            tick();
        end
        chk("t3_handshakes", hs, 2);
        chk("t3_done", done, 3'b001);
        req = '0;
        tick();
        chk_idle("t3_end");

        // Zero-length message
        do_reset();
        set_len(1, 0);
        tx_data_ready = 1'b1;
        req = 3'b010;
        tick();
        chk("t4_grant", grant, 3'b010);
        chk("t4_done", done, 3'b010);
        chk("t4_valid", tx_data_valid, 0);
        req = '0;
        tick();
        chk_idle("t4_end");

        // Request drop and length change mid-message
        do_reset();
        set_len(0, 4);
        tx_data_ready = 1'b1;
        req = 3'b001;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk_send("t5", 3'b001, 0, k);
            if (k == 1) begin
                req = '0;
                set_len(0, 1);
            end
            tick();
        end
        chk("t5_done", done, 3'b001);
        tick();
        chk_idle("t5_end");

        // Reset during byte 2 of 5
        do_reset();
        set_len(0, 5);
        set_len(1, 2);
        tx_data_ready = 1'b1;
        req = 3'b001;
        tick();
        tick();
        tick();
        chk_send("t6_pre", 3'b001, 0, 2);
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk_idle("t6_async");
        chk("t6_idx", byte_idx, 0);
        req = 3'b011;
        tick();
        chk_idle("t6_held");
        sys_rst_n = 1'b1;
        tick();
        chk_send("t6_first", 3'b001, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
